// File: rtl/arm_defs.sv
// Shared definitions for the ARM immediate encoder: FSM state encoding
// and the field widths of the shifter-operand immediate form.
package arm_defs;

    typedef enum logic {
        ENC_IDLE   = 1'b0,
        ENC_SEARCH = 1'b1
    } enc_state_t;

    localparam int IMM8_W = 8;
    localparam int ROT_W  = 4;

    localparam logic [ROT_W-1:0] MAX_ROT = 4'd15;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result bundle for the immediate encoder. The master side issues
// start/value and observes the search status and result.
interface imm_encoder_if #(
    parameter int DATA_W = 32,
    parameter int OPR_W  = 12
);
    logic              start;
    logic [DATA_W-1:0] value;
    logic              busy;
    logic              done;
    logic              valid;
    logic [OPR_W-1:0]  shift_operand;

    modport master (
        output start, value,
        input  busy, done, valid, shift_operand
    );

    modport slave (
        input  start, value,
        output busy, done, valid, shift_operand
    );
endinterface

// File: rtl/imm_encoder_rol_even.sv
// Combinational rotate-left by an even amount (2*rot), the inverse direction
// of the Val2 rotate-right used when decoding an immediate.
module rol_even
    import arm_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] in,
    input  logic [ROT_W-1:0]  rot,
    output logic [DATA_W-1:0] out
);
    logic [ROT_W:0]      amt;
    logic [2*DATA_W-1:0] dbl;

    // Doubling the word turns the rotate into a plain shift; amount 0..30.
    always_comb begin
        amt = {rot, 1'b0};
        dbl = {in, in} << amt;
        out = dbl[2*DATA_W-1:DATA_W];
    end
endmodule

// File: rtl/imm_encoder.sv
// Iterative ARM data-processing immediate encoder. Tries one even rotation
// per cycle, starting at zero so the first hit is the canonical encoding,
// and reports "not encodable" after all sixteen rotations miss.
module imm_encoder
    import arm_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int OPR_W  = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_encoder_if.slave bus
);
    enc_state_t        state;
    logic [DATA_W-1:0] val_q;
    logic [ROT_W-1:0]  rot;
    logic [DATA_W-1:0] cand;
    logic              hit;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic [OPR_W-1:0]  opr_q;

    rol_even #(.DATA_W(DATA_W)) u_rol (
        .in  (val_q),
        .rot (rot),
        .out (cand)
    );

    // A rotation fits when everything above the low byte is zero.
    always_comb begin
        hit = (cand[DATA_W-1:IMM8_W] == '0);
    end

    // Search FSM; done is a one-cycle pulse, result fields move only with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ENC_IDLE;
            val_q   <= '0;
            rot     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            opr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ENC_IDLE: begin
                    if (bus.start) begin
                        val_q  <= bus.value;
                        rot    <= '0;
                        busy_q <= 1'b1;
                        state  <= ENC_SEARCH;
                    end
                end
                ENC_SEARCH: begin
                    if (hit) begin
                        opr_q   <= {rot, cand[IMM8_W-1:0]};
                        valid_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= ENC_IDLE;
                    end else if (rot == MAX_ROT) begin
                        opr_q   <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= ENC_IDLE;
                    end else begin
                        rot <= rot + 1'b1;
                    end
                end
                default: state <= ENC_IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.valid         = valid_q;
    assign bus.shift_operand = opr_q;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with an independent exhaustive reference
// encoder and a Val2 (rotate-right) decode check on every result.
module tb_imm_encoder;
    logic clk;
    logic rst_n;

    int checks = 0;
    int passed = 0;

    imm_encoder_if #(.DATA_W(32), .OPR_W(12)) bus ();

    imm_encoder #(.DATA_W(32), .OPR_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int amt);
        logic [63:0] d;
        d = {x, x} >> (amt % 32);
        return d[31:0];
    endfunction

    // Reference: smallest r with ROR(b, 2r) == v for some byte b.
    task automatic ref_enc(input logic [31:0] v, output logic vld,
                           output logic [11:0] so, output int k);
        vld = 1'b0; so = 12'h000; k = 15;
        for (int r = 0; r < 16; r++) begin
            for (int b = 0; b < 256; b++) begin
                if (!vld && ror32(32'(b), 2 * r) == v) begin
                    vld = 1'b1; so = {4'(r), 8'(b)}; k = r;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic accept(input logic [31:0] v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; counts edges until done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (lat < 40) begin
            @(posedge clk);
            #1 lat++;
            if (bus.done) break;
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] v);
        int lat, bcnt, k;
        logic evld;
        logic [11:0] eso;
        ref_enc(v, evld, eso, k);
        accept(v);
        wait_done(lat, bcnt);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_lat"}, 32'(lat), evld ? 32'(k + 1) : 32'd16);
        chk({tag, "_valid"}, 32'(bus.valid), 32'(evld));
        chk({tag, "_so"}, 32'(bus.shift_operand), 32'(eso));
        if (bus.valid === 1'b1)
            chk({tag, "_val2"}, ror32(32'(bus.shift_operand[7:0]),
                2 * int'(bus.shift_operand[11:8])), v);
        @(posedge clk);
        #1 chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat, bcnt;
        logic saw_done;
        logic [31:0] v;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.value = '0;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_so", 32'(bus.shift_operand), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed vectors
        accept(32'h000000FF);
        wait_done(lat, bcnt);
        chk("ff_lat", 32'(lat), 32'd1);
        chk("ff_valid", 32'(bus.valid), 32'd1);
        chk("ff_so", 32'(bus.shift_operand), 32'h0FF);

        accept(32'hFF000000);
        wait_done(lat, bcnt);
        chk("ff000000_lat", 32'(lat), 32'd5);
        chk("ff000000_valid", 32'(bus.valid), 32'd1);
        chk("ff000000_so", 32'(bus.shift_operand), 32'h4FF);

        accept(32'h00000101);
        wait_done(lat, bcnt);
        chk("101_lat", 32'(lat), 32'd16);
        chk("101_busy_cycles", 32'(bcnt), 32'd16);
        chk("101_valid", 32'(bus.valid), 32'd0);
        chk("101_so", 32'(bus.shift_operand), 32'h000);

        accept(32'h000003FC);
        wait_done(lat, bcnt);
        chk("3fc_lat", 32'(lat), 32'd16);
        chk("3fc_valid", 32'(bus.valid), 32'd1);
        chk("3fc_so", 32'(bus.shift_operand), 32'hFFF);

        // Start while busy is ignored, result fields stay put meanwhile
        accept(32'hF000000F);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'h00000001;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("ign_busy", 32'(bus.busy), 32'd1);
        chk("ign_hold_valid", 32'(bus.valid), 32'd1);
        chk("ign_hold_so", 32'(bus.shift_operand), 32'hFFF);
        wait_done(lat, bcnt);
        chk("ign_lat", 32'(lat + 1), 32'd3);
        chk("ign_valid", 32'(bus.valid), 32'd1);
        chk("ign_so", 32'(bus.shift_operand), 32'h2FF);

        // Start in the done cycle is accepted
        bus.start = 1'b1;
        bus.value = 32'h00000000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("b2b_done_low", 32'(bus.done), 32'd0);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(lat, bcnt);
        chk("zero_lat", 32'(lat), 32'd1);
        chk("zero_valid", 32'(bus.valid), 32'd1);
        chk("zero_so", 32'(bus.shift_operand), 32'h000);

        // Reset in the middle of a search
        accept(32'h000000FF);
        wait_done(lat, bcnt);
        accept(32'h00000101);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_valid", 32'(bus.valid), 32'd0);
        chk("mid_rst_so", 32'(bus.shift_operand), 32'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (bus.done) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", 32'(saw_done), 32'd0);
        accept(32'h000000FF);
        wait_done(lat, bcnt);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_so", 32'(bus.shift_operand), 32'h0FF);

        // Sweep: constructed encodable values and random words
        for (int i = 0; i < 6; i++) begin
            v = ror32(32'($urandom_range(1, 255)), 2 * int'($urandom_range(0, 15)));
            run($sformatf("enc%0d", i), v);
        end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            run($sformatf("rnd%0d", i), v);
        end
        run("big", 32'hC000003F);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
